// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: register enables/flushes for load-use, branch and data-memory waits,
// EX-stage forwarding selects and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic [4:0]       mem_rd,
  input  logic             mem_RegWrite,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_RegWrite,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             pipe_hold,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);

  logic [0:0] state;
  logic [7:0] wait_cnt;
  logic       hold;
  logic       timeout;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_RegWrite && (mem_rd != '0) && (mem_rd == rs))
      return 2'b10;
    else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    hold     = mem_access & ~mem_ready & (wait_cnt < MAX_W);
    timeout  = (state == MEM_WAIT) & mem_access & ~mem_ready & (wait_cnt == MAX_W);
    load_use = ex_MemRead & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

  // Reset gates every output so the pipeline sees reset values asynchronously.
  // A timeout releases the pipeline, so branch/load-use still apply in that cycle.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    pipe_hold   = 1'b0;
    mem_timeout = 1'b0;
    forward_a   = 2'b00;
    forward_b   = 2'b00;
    if (!reset) begin
      forward_a = fwd_sel(ex_rs1);
      forward_b = fwd_sel(ex_rs2);
      if (hold) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_hold   = 1'b1;
        memwb_flush = 1'b1;
      end else begin
        if (timeout) begin
          mem_timeout = 1'b1;
          memwb_flush = 1'b1;
        end
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else if (hold) begin
      state    <= MEM_WAIT;
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      state    <= RUN;
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (!pc_write && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
